tt_um_emern_raster: RTL and testbench



---
 rtl/tt_um_emern_raster_pkg.sv | 44 ++++
 rtl/tt_um_emern_edge_fn.sv | 19 +
 rtl/tt_um_emern_raster.sv | 218 +++++++++++++++++++++
 tb/tb_tt_um_emern_raster.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_emern_raster_pkg.sv
// Shared widths, stage-1 difference bundle and coverage helper for the triangle rasterizer.
// Optional shadow register set is selected by the RASTER_SHADOW_EN macro in tt_um_emern_raster.sv.
package tt_um_emern_raster_pkg;

    localparam int WCOLOR         = 6;
    localparam int WPX            = 7;
    localparam int WPY            = 6;
    localparam int N_POLY         = 4;
    localparam int WEDGE          = 16;
    localparam int RASTER_LATENCY = 3;

    localparam int WDX   = WPX + 1;
    localparam int WDY   = WPY + 1;
    localparam int WPROD = WDX + WDY;

    typedef struct packed {
        logic signed [WDX-1:0] dpx;
        logic signed [WDY-1:0] dpy;
        logic signed [WDX-1:0] dex;
        logic signed [WDY-1:0] dey;
    } edge_diff_t;

    function automatic logic signed [WDX-1:0] diff_x(input logic [WPX-1:0] a, input logic [WPX-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [WDY-1:0] diff_y(input logic [WPY-1:0] a, input logic [WPY-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Either winding is accepted; a zero on any edge counts for both windings.
    function automatic logic poly_covers(input logic signed [WEDGE-1:0] area,
                                         input logic signed [WEDGE-1:0] e0,
                                         input logic signed [WEDGE-1:0] e1,
                                         input logic signed [WEDGE-1:0] e2);
        logic all_ge;
        logic all_le;
        all_ge = !e0[WEDGE-1] && !e1[WEDGE-1] && !e2[WEDGE-1];
        all_le = (e0[WEDGE-1] || (e0 == '0)) && (e1[WEDGE-1] || (e1 == '0)) &&
                 (e2[WEDGE-1] || (e2 == '0));
        return (area != '0) && (all_ge || all_le);
    endfunction

endpackage

// File: rtl/tt_um_emern_edge_fn.sv
// Combinational signed edge function: E = dpx*dey - dpy*dex, exact at every width.
module tt_um_emern_edge_fn
    import tt_um_emern_raster_pkg::*;
(
    input  logic signed [WDX-1:0]   dpx,
    input  logic signed [WDY-1:0]   dpy,
    input  logic signed [WDX-1:0]   dex,
    input  logic signed [WDY-1:0]   dey,
    output logic signed [WEDGE-1:0] e
);

    logic signed [WPROD-1:0] p0;
    logic signed [WPROD-1:0] p1;

    assign p0 = WPROD'(dpx) * WPROD'(dey);
    assign p1 = WPROD'(dpy) * WPROD'(dex);
    assign e  = WEDGE'(p0) - WEDGE'(p1);

endmodule

// File: rtl/tt_um_emern_raster.sv
// Three-stage per-pixel triangle rasterizer: differences, edge/area functions, priority resolve.
// Define RASTER_SHADOW_EN to latch the frontend registers only on frame_start_in (tear-free frames).
module tt_um_emern_raster
    import tt_um_emern_raster_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_valid_in,
    input  logic [WPX-1:0]             pix_x_in,
    input  logic [WPY-1:0]             pix_y_in,
    input  logic                       frame_start_in,
    input  logic [WCOLOR-1:0]          bg_color_in,
    input  logic [WCOLOR*N_POLY-1:0]   poly_color_in,
    input  logic [WPX*N_POLY-1:0]      v0_x_in,
    input  logic [WPX*N_POLY-1:0]      v1_x_in,
    input  logic [WPX*N_POLY-1:0]      v2_x_in,
    input  logic [WPY*N_POLY-1:0]      v0_y_in,
    input  logic [WPY*N_POLY-1:0]      v1_y_in,
    input  logic [WPY*N_POLY-1:0]      v2_y_in,
    input  logic [N_POLY-1:0]          poly_enable_in,
    output logic [WCOLOR-1:0]          color_out,
    output logic                       color_valid_out
);

    logic [WCOLOR-1:0]        src_bg;
    logic [WCOLOR*N_POLY-1:0] src_color;
    logic [WPX*N_POLY-1:0]    src_v0_x, src_v1_x, src_v2_x;
    logic [WPY*N_POLY-1:0]    src_v0_y, src_v1_y, src_v2_y;
    logic [N_POLY-1:0]        src_en;

`ifdef RASTER_SHADOW_EN
    logic [WCOLOR-1:0]        bg_shadow_reg;
    logic [WCOLOR*N_POLY-1:0] color_shadow_reg;
    logic [WPX*N_POLY-1:0]    v0_x_shadow_reg, v1_x_shadow_reg, v2_x_shadow_reg;
    logic [WPY*N_POLY-1:0]    v0_y_shadow_reg, v1_y_shadow_reg, v2_y_shadow_reg;
    logic [N_POLY-1:0]        en_shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_shadow_reg    <= '0;
            color_shadow_reg <= '0;
            v0_x_shadow_reg  <= '0;
            v1_x_shadow_reg  <= '0;
            v2_x_shadow_reg  <= '0;
            v0_y_shadow_reg  <= '0;
            v1_y_shadow_reg  <= '0;
            v2_y_shadow_reg  <= '0;
            en_shadow_reg    <= '0;
        end else if (frame_start_in) begin
            bg_shadow_reg    <= bg_color_in;
            color_shadow_reg <= poly_color_in;
            v0_x_shadow_reg  <= v0_x_in;
            v1_x_shadow_reg  <= v1_x_in;
            v2_x_shadow_reg  <= v2_x_in;
            v0_y_shadow_reg  <= v0_y_in;
            v1_y_shadow_reg  <= v1_y_in;
            v2_y_shadow_reg  <= v2_y_in;
            en_shadow_reg    <= poly_enable_in;
        end
    end

    assign src_bg    = bg_shadow_reg;
    assign src_color = color_shadow_reg;
    assign src_v0_x  = v0_x_shadow_reg;
    assign src_v1_x  = v1_x_shadow_reg;
    assign src_v2_x  = v2_x_shadow_reg;
    assign src_v0_y  = v0_y_shadow_reg;
    assign src_v1_y  = v1_y_shadow_reg;
    assign src_v2_y  = v2_y_shadow_reg;
    assign src_en    = en_shadow_reg;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start_in;

    assign src_bg    = bg_color_in;
    assign src_color = poly_color_in;
    assign src_v0_x  = v0_x_in;
    assign src_v1_x  = v1_x_in;
    assign src_v2_x  = v2_x_in;
    assign src_v0_y  = v0_y_in;
    assign src_v1_y  = v1_y_in;
    assign src_v2_y  = v2_y_in;
    assign src_en    = poly_enable_in;
`endif

    // Colours, background and enables ride with the pixel so one pixel sees one snapshot.
    logic                     s1_valid_reg, s2_valid_reg;
    logic [WCOLOR-1:0]        s1_bg_reg, s2_bg_reg;
    logic [WCOLOR*N_POLY-1:0] s1_color_reg, s2_color_reg;
    logic [N_POLY-1:0]        s1_en_reg, s2_en_reg;
    logic [N_POLY-1:0]        s2_cover;
    logic [WCOLOR-1:0]        color_next;
    logic [WCOLOR-1:0]        color_out_reg;
    logic                     color_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_bg_reg    <= '0;
            s1_color_reg <= '0;
            s1_en_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_bg_reg    <= '0;
            s2_color_reg <= '0;
            s2_en_reg    <= '0;
        end else begin
            s1_valid_reg <= pix_valid_in;
            s1_bg_reg    <= src_bg;
            s1_color_reg <= src_color;
            s1_en_reg    <= src_en;
            s2_valid_reg <= s1_valid_reg;
            s2_bg_reg    <= s1_bg_reg;
            s2_color_reg <= s1_color_reg;
            s2_en_reg    <= s1_en_reg;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_POLY; gi++) begin : g_poly
            logic [WPX-1:0]          vx [3];
            logic [WPY-1:0]          vy [3];
            edge_diff_t              diff_next [3];
            edge_diff_t              diff_reg  [3];
            logic signed [WDX-1:0]   ax2_next, ax2_reg;
            logic signed [WDY-1:0]   ay2_next, ay2_reg;
            logic signed [WEDGE-1:0] e_next [3];
            logic signed [WEDGE-1:0] e_reg  [3];
            logic signed [WEDGE-1:0] area_next, area_reg;

            assign vx[0] = src_v0_x[gi*WPX +: WPX];
            assign vx[1] = src_v1_x[gi*WPX +: WPX];
            assign vx[2] = src_v2_x[gi*WPX +: WPX];
            assign vy[0] = src_v0_y[gi*WPY +: WPY];
            assign vy[1] = src_v1_y[gi*WPY +: WPY];
            assign vy[2] = src_v2_y[gi*WPY +: WPY];

            // Edge k runs from vertex k to vertex (k+1) mod 3.
            always_comb begin
                for (int k = 0; k < 3; k++) begin
                    diff_next[k].dpx = diff_x(pix_x_in, vx[k]);
                    diff_next[k].dpy = diff_y(pix_y_in, vy[k]);
                    diff_next[k].dex = diff_x(vx[(k+1)%3], vx[k]);
                    diff_next[k].dey = diff_y(vy[(k+1)%3], vy[k]);
                end
                ax2_next = diff_x(vx[2], vx[0]);
                ay2_next = diff_y(vy[2], vy[0]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < 3; k++) begin
                        diff_reg[k] <= '0;
                        e_reg[k]    <= '0;
                    end
                    ax2_reg  <= '0;
                    ay2_reg  <= '0;
                    area_reg <= '0;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        diff_reg[k] <= diff_next[k];
                        e_reg[k]    <= e_next[k];
                    end
                    ax2_reg  <= ax2_next;
                    ay2_reg  <= ay2_next;
                    area_reg <= area_next;
                end
            end

            for (gj = 0; gj < 3; gj++) begin : g_edge
                tt_um_emern_edge_fn u_edge (
                    .dpx (diff_reg[gj].dpx),
                    .dpy (diff_reg[gj].dpy),
                    .dex (diff_reg[gj].dex),
                    .dey (diff_reg[gj].dey),
                    .e   (e_next[gj])
                );
            end

            // Area reuses edge 0's direction vector with v2 as the test point.
            tt_um_emern_edge_fn u_area (
                .dpx (ax2_reg),
                .dpy (ay2_reg),
                .dex (diff_reg[0].dex),
                .dey (diff_reg[0].dey),
                .e   (area_next)
            );

            assign s2_cover[gi] = s2_en_reg[gi] && poly_covers(area_reg, e_reg[0], e_reg[1], e_reg[2]);
        end
    endgenerate

    // Lowest index wins, so scan from the top down.
    always_comb begin
        color_next = s2_bg_reg;
        for (int i = N_POLY - 1; i >= 0; i--) begin
            if (s2_cover[i]) begin
                color_next = s2_color_reg[i*WCOLOR +: WCOLOR];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_out_reg   <= '0;
            color_valid_reg <= 1'b0;
        end else begin
            color_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                color_out_reg <= color_next;
            end
        end
    end

    assign color_out       = color_out_reg;
    assign color_valid_out = color_valid_reg;

endmodule

// File: tb/tb_tt_um_emern_raster.sv
// Scoreboard bench for tt_um_emern_raster: directed cases, random frames and a mid-stream reset.
module tb_tt_um_emern_raster;
    import tt_um_emern_raster_pkg::*;

`ifdef RASTER_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     pix_valid_in;
    logic [WPX-1:0]           pix_x_in;
    logic [WPY-1:0]           pix_y_in;
    logic                     frame_start_in;
    logic [WCOLOR-1:0]        bg_color_in;
    logic [WCOLOR*N_POLY-1:0] poly_color_in;
    logic [WPX*N_POLY-1:0]    v0_x_in, v1_x_in, v2_x_in;
    logic [WPY*N_POLY-1:0]    v0_y_in, v1_y_in, v2_y_in;
    logic [N_POLY-1:0]        poly_enable_in;
    logic [WCOLOR-1:0]        color_out;
    logic                     color_valid_out;

    always #5 clk = ~clk;

    tt_um_emern_raster dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid_in    (pix_valid_in),
        .pix_x_in        (pix_x_in),
        .pix_y_in        (pix_y_in),
        .frame_start_in  (frame_start_in),
        .bg_color_in     (bg_color_in),
        .poly_color_in   (poly_color_in),
        .v0_x_in         (v0_x_in),
        .v1_x_in         (v1_x_in),
        .v2_x_in         (v2_x_in),
        .v0_y_in         (v0_y_in),
        .v1_y_in         (v1_y_in),
        .v2_y_in         (v2_y_in),
        .poly_enable_in  (poly_enable_in),
        .color_out       (color_out),
        .color_valid_out (color_valid_out)
    );

    // Frontend register image (live) and the model's own frame snapshot.
    int cfg_vx [N_POLY][3];
    int cfg_vy [N_POLY][3];
    int cfg_col [N_POLY];
    int cfg_en [N_POLY];
    int cfg_bg;
    int sh_vx [N_POLY][3];
    int sh_vy [N_POLY][3];
    int sh_col [N_POLY];
    int sh_en [N_POLY];
    int sh_bg;

    typedef struct { int color; int cyc; } exp_t;
    exp_t exp_q [$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int last_color = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int edge_val(int ax, int ay, int bx, int by, int px, int py);
        return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
    endfunction

    // Colour a pixel gets from the snapshot it is sampled with.
    function automatic int ref_color(int px, int py);
        int vx [3];
        int vy [3];
        int e [3];
        int area;
        for (int i = 0; i < N_POLY; i++) begin
            for (int k = 0; k < 3; k++) begin
                vx[k] = SHADOW ? sh_vx[i][k] : cfg_vx[i][k];
                vy[k] = SHADOW ? sh_vy[i][k] : cfg_vy[i][k];
            end
            for (int k = 0; k < 3; k++)
                e[k] = edge_val(vx[k], vy[k], vx[(k+1)%3], vy[(k+1)%3], px, py);
            area = edge_val(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
            if ((SHADOW ? sh_en[i] : cfg_en[i]) != 0 && area != 0 &&
                ((e[0] >= 0 && e[1] >= 0 && e[2] >= 0) || (e[0] <= 0 && e[1] <= 0 && e[2] <= 0)))
                return SHADOW ? sh_col[i] : cfg_col[i];
        end
        return SHADOW ? sh_bg : cfg_bg;
    endfunction

    task automatic load_shadow();
        for (int i = 0; i < N_POLY; i++) begin
            for (int k = 0; k < 3; k++) begin
                sh_vx[i][k] = cfg_vx[i][k];
                sh_vy[i][k] = cfg_vy[i][k];
            end
            sh_col[i] = cfg_col[i];
            sh_en[i]  = cfg_en[i];
        end
        sh_bg = cfg_bg;
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < N_POLY; i++) begin
            for (int k = 0; k < 3; k++) begin
                sh_vx[i][k] = 0;
                sh_vy[i][k] = 0;
            end
            sh_col[i] = 0;
            sh_en[i]  = 0;
        end
        sh_bg = 0;
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < N_POLY; i++) begin
            v0_x_in[i*WPX +: WPX] = WPX'(cfg_vx[i][0]);
            v1_x_in[i*WPX +: WPX] = WPX'(cfg_vx[i][1]);
            v2_x_in[i*WPX +: WPX] = WPX'(cfg_vx[i][2]);
            v0_y_in[i*WPY +: WPY] = WPY'(cfg_vy[i][0]);
            v1_y_in[i*WPY +: WPY] = WPY'(cfg_vy[i][1]);
            v2_y_in[i*WPY +: WPY] = WPY'(cfg_vy[i][2]);
            poly_color_in[i*WCOLOR +: WCOLOR] = WCOLOR'(cfg_col[i]);
            poly_enable_in[i] = (cfg_en[i] != 0);
        end
        bg_color_in = WCOLOR'(cfg_bg);
    endtask

    task automatic set_poly(int i, int x0, int y0, int x1, int y1, int x2, int y2, int col, int en);
        cfg_vx[i][0] = x0; cfg_vy[i][0] = y0;
        cfg_vx[i][1] = x1; cfg_vy[i][1] = y1;
        cfg_vx[i][2] = x2; cfg_vy[i][2] = y2;
        cfg_col[i] = col;
        cfg_en[i]  = en;
    endtask

    // One cycle of stimulus: pixel, frame pulse and the current register image.
    task automatic pix(int x, int y, bit v, bit fs = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        pix_valid_in   = v;
        pix_x_in       = WPX'(x);
        pix_y_in       = WPY'(y);
        frame_start_in = fs;
        drive_cfg();
        if (v) begin
            e.color = ref_color(x, y);
            e.cyc   = cyc;
            exp_q.push_back(e);
        end
        if (fs) load_shadow();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) pix(0, 0, 1'b0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: pop on every valid output, and check the hold value on bubbles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (color_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", int'(color_valid_out), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("color", int'(color_out), e.color);
                    check("latency", cyc - e.cyc, RASTER_LATENCY);
                    $display("pixel issued@%0d out@%0d color=%02h expected=%02h", e.cyc, cyc, color_out, e.color);
                    last_color = e.color;
                end
            end else begin
                check("bubble_hold", int'(color_out), last_color);
            end
        end
    end

    initial begin
        pix_valid_in = 1'b0; pix_x_in = '0; pix_y_in = '0; frame_start_in = 1'b0;
        for (int i = 0; i < N_POLY; i++) set_poly(i, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_bg = 0;
        clear_shadow();
        drive_cfg();
        repeat (3) @(posedge clk);
        #1;
        check("reset_color", int'(color_out), 0);
        check("reset_valid", int'(color_valid_out), 0);
        #1 rst_n = 1'b1;

        // Basic triangle A, outside point, hypotenuse and vertex.
        cfg_bg = 'h03;
        set_poly(0, 10, 10, 30, 10, 10, 30, 'h30, 1);
        pix(0, 0, 1'b0, 1'b1);
        pix(15, 15, 1'b1);
        pix(40, 40, 1'b1);
        pix(20, 20, 1'b1);
        pix(10, 10, 1'b1);
        // Opposite winding.
        set_poly(0, 10, 30, 30, 10, 10, 10, 'h30, 1);
        pix(0, 0, 1'b0, 1'b1);
        pix(15, 15, 1'b1);
        // Priority between identical A and B.
        set_poly(0, 10, 10, 30, 10, 10, 30, 'h30, 1);
        set_poly(1, 10, 10, 30, 10, 10, 30, 'h0C, 1);
        pix(0, 0, 1'b0, 1'b1);
        pix(15, 15, 1'b1);
        cfg_en[0] = 0;
        pix(0, 0, 1'b0, 1'b1);
        pix(15, 15, 1'b1);
        cfg_en[1] = 0;
        pix(0, 0, 1'b0, 1'b1);
        pix(15, 15, 1'b1);
        // Degenerate triangles never cover.
        set_poly(0, 5, 5, 5, 5, 5, 5, 'h30, 1);
        pix(0, 0, 1'b0, 1'b1);
        pix(5, 5, 1'b1);
        set_poly(0, 0, 0, 10, 10, 20, 20, 'h30, 1);
        pix(0, 0, 1'b0, 1'b1);
        pix(10, 10, 1'b1);
        // Mid-frame colour change with a frame pulse alongside a pixel.
        set_poly(0, 10, 10, 30, 10, 10, 30, 'h30, 1);
        pix(0, 0, 1'b0, 1'b1);
        cfg_col[0] = 'h3F;
        pix(15, 15, 1'b1);
        pix(15, 15, 1'b1, 1'b1);
        pix(15, 15, 1'b1);
        pix(16, 12, 1'b1);
        drain();

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) pix($urandom_range(0, 40), $urandom_range(0, 40), 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_color", int'(color_out), 0);
        check("midreset_valid", int'(color_valid_out), 0);
        exp_q.delete();
        last_color = 0;
        clear_shadow();
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) pix($urandom_range(0, 40), $urandom_range(0, 40), 1'b1);
        pix(0, 0, 1'b0, 1'b1);
        drain();

        // Random frames with random bubbles and unsynchronised register writes.
        for (int it = 0; it < 300; it++) begin
            if (it % 25 == 0 || $urandom_range(0, 30) == 0) begin
                int i;
                int bx;
                int by;
                i  = $urandom_range(0, N_POLY - 1);
                bx = $urandom_range(0, 90);
                by = $urandom_range(0, 30);
                if ($urandom_range(0, 7) == 0)
                    set_poly(i, bx, by, bx + 10, by + 5, bx + 20, by + 10, $urandom_range(0, 63), 1);
                else
                    set_poly(i, bx + $urandom_range(0, 37), by + $urandom_range(0, 33),
                                bx + $urandom_range(0, 37), by + $urandom_range(0, 33),
                                bx + $urandom_range(0, 37), by + $urandom_range(0, 33),
                                $urandom_range(0, 63), ($urandom_range(0, 4) != 0) ? 1 : 0);
                if ($urandom_range(0, 3) == 0) cfg_bg = $urandom_range(0, 63);
            end
            pix($urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 4) != 0,
                $urandom_range(0, 15) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
